mem_completer: RTL and testbench
================================

MEM_COMPLETER -- requirements
Module: mem_completer

Interface
REQ-001 SHALL have parameter ADDR_RANGE, default 32768, memory depth in BUS_WIDTH-bit words; addresses are word addresses.
REQ-002 SHALL have parameter LENGTH_RANGE, default 32, maximum burst length in beats.
REQ-003 SHALL have parameter BUS_WIDTH, default 32, data beat width.
REQ-004 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port rd, input, 1, read burst request.
REQ-007 SHALL have port wr, input, 1, write beat valid.
REQ-008 SHALL have port addr, input, $clog2(ADDR_RANGE), request or current-beat word address.
REQ-009 SHALL have port length, input, $clog2(LENGTH_RANGE)+1, burst length in beats.
REQ-010 SHALL have port mode, input, 2, access mode: 01 unit-stride, 10 strided, 11 indexed, 00 treated as unit-stride.
REQ-011 SHALL have port wrdata, input, BUS_WIDTH, write beat data.
REQ-012 SHALL have port rddataready, input, 1, requestor accepts the read beat.
REQ-013 SHALL have port ready, output, 1, completer accepts a request or write beat.
REQ-014 SHALL have port rddata, output, BUS_WIDTH, read beat data, registered.
REQ-015 SHALL have port rddatavalid, output, 1, rddata holds a valid beat, registered.
REQ-016 SHALL have port busy, output, 1, burst in progress (state != IDLE).
REQ-017 SHALL have port protocol_err, output, 1, one-cycle pulse on a malformed request.

Function
REQ-018 SHALL contain an ADDR_RANGE x BUS_WIDTH storage array; it is not cleared by reset.
REQ-019 SHALL implement states IDLE, WRITE_BURST, READ_FETCH, READ_VALID.
REQ-020 SHALL assert ready combinationally in IDLE and WRITE_BURST only; ready is 0 in READ_FETCH and READ_VALID.
REQ-021 SHALL, on accepting a request in IDLE, latch base address = addr, mode, and burst length L = length; length 0 or length > LENGTH_RANGE gives L = 1 and pulses protocol_err.
REQ-022 SHALL keep a beat counter b, 0..L-1, cleared on request accept.
REQ-023 SHALL form the effective address as base+b for mode 01/00 and as the live addr input for modes 10/11, truncated modulo ADDR_RANGE (wrap-around).
REQ-024 SHALL treat a write handshake as wr & ready; beat 0 is accepted in IDLE in the same cycle wr is first seen.
REQ-025 SHALL write wrdata to the storage at the effective address on every write handshake; one beat per cycle.
REQ-026 SHALL, after a write handshake with b = L-1, go to IDLE (L = 1 stays in IDLE); otherwise go to or stay in WRITE_BURST with b+1.
REQ-027 SHALL ignore rd while in WRITE_BURST.
REQ-028 SHALL, on rd in IDLE (rd & ready), move to READ_FETCH; if rd and wr are both high in IDLE, serve the read, ignore the write beat, and pulse protocol_err.
REQ-029 SHALL, in READ_FETCH, register storage[effective address] into rddata at the clock edge and move to READ_VALID; rddatavalid is 0 during READ_FETCH.
REQ-030 SHALL, in READ_VALID, hold rddatavalid = 1 and rddata stable until rddataready.
REQ-031 SHALL, on rddataready in READ_VALID, clear rddatavalid at the next edge; if b = L-1, go to IDLE, else increment b and go to READ_FETCH.
REQ-032 SHALL therefore take at least 2 cycles per read beat; the first rddatavalid appears 2 cycles after the rd handshake.
REQ-033 SHALL ignore wr and rd while in read states.
REQ-034 SHALL deassert busy the cycle after the final beat handshake.

Reset
REQ-035 SHALL, on rst, force state IDLE, b = 0, rddata = 0, rddatavalid = 0, protocol_err = 0, and the latched base, mode and length to 0, immediately and regardless of clk.
REQ-036 SHALL, on rst during a burst, abandon the burst; storage words already written keep their values; ready = 1 and busy = 0 once rst is released.

Verification
REQ-037 Unit-stride write then read: write addr=0x100, mode=01, length=8, data 0xA0..0xA7 on 8 consecutive cycles, then read the same burst -> ready stays high for 8 beats, busy falls after beat 7, and the read returns 0xA0..0xA7 in order with each rddatavalid 2 cycles after the previous handshake.
REQ-038 Strided read with backpressure: mode=10, length=4, addr sequence 0x10, 0x14, 0x18, 0x1C, rddataready held low 3 cycles on beat 1 -> rddata stays stable while rddatavalid is held, and all 4 words are returned in order.
REQ-039 Wrap-around: mode=01, addr=ADDR_RANGE-2, length=4 write -> words land at ADDR_RANGE-2, ADDR_RANGE-1, 0, 1.
REQ-040 Malformed requests: length=0 write -> exactly 1 beat is written and protocol_err pulses 1 cycle; rd=wr=1 in IDLE -> a read is started, nothing is written, and protocol_err pulses.
REQ-041 Reset mid-burst: assert rst on write beat 3 of 8 -> state returns to IDLE with busy=0, beats 0-2 are retained, and a subsequent 1-beat read of beat 2 returns its data.

Source files
------------

// File: rtl/mem_completer.sv
// Burst memory completer: unit-stride, strided and indexed read/write bursts
// over a single-port word-addressed storage array with a registered read beat.
module mem_completer #(
    parameter int ADDR_RANGE   = 32768,
    parameter int LENGTH_RANGE = 32,
    parameter int BUS_WIDTH    = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rd,
    input  logic                            wr,
    input  logic [$clog2(ADDR_RANGE)-1:0]   addr,
    input  logic [$clog2(LENGTH_RANGE):0]   length,
    input  logic [1:0]                      mode,
    input  logic [BUS_WIDTH-1:0]            wrdata,
    input  logic                            rddataready,
    output logic                            ready,
    output logic [BUS_WIDTH-1:0]            rddata,
    output logic                            rddatavalid,
    output logic                            busy,
    output logic                            protocol_err
);

    localparam int AW = $clog2(ADDR_RANGE);
    localparam int LW = $clog2(LENGTH_RANGE) + 1;

    typedef enum logic [1:0] {
        IDLE,
        WRITE_BURST,
        READ_FETCH,
        READ_VALID
    } state_t;

    state_t                 state_q;
    logic [AW-1:0]          base_q;
    logic [1:0]             mode_q;
    logic [LW-1:0]          len_q;
    logic [LW-1:0]          beat_q;
    logic [BUS_WIDTH-1:0]   rddata_q;
    logic                   rddatavalid_q;
    logic                   perr_q;

    logic [BUS_WIDTH-1:0]   mem [ADDR_RANGE];

    logic                   bad_len_d;
    logic [LW-1:0]          len_d;
    logic [AW:0]            sum_d;
    logic [AW-1:0]          eff_addr_d;
    logic                   strided_d;
    logic                   last_d;
    logic                   we_d;

    assign ready        = (state_q == IDLE) || (state_q == WRITE_BURST);
    assign busy         = (state_q != IDLE);
    assign rddata       = rddata_q;
    assign rddatavalid  = rddatavalid_q;
    assign protocol_err = perr_q;

    assign bad_len_d = (length == '0) || (length > LW'(LENGTH_RANGE));
    assign len_d     = bad_len_d ? LW'(1) : length;
    assign strided_d = (mode_q == 2'b10) || (mode_q == 2'b11);
    assign last_d    = (beat_q == len_q - LW'(1));
    // A read request in IDLE wins over a simultaneous write beat.
    assign we_d      = wr && ready && !((state_q == IDLE) && rd);

    // Unit-stride address wraps modulo ADDR_RANGE, also for non-power-of-two depths.
    always_comb begin
        sum_d = {1'b0, base_q} + (AW+1)'(beat_q);
        if (sum_d >= (AW+1)'(ADDR_RANGE)) begin
            sum_d = sum_d - (AW+1)'(ADDR_RANGE);
        end
        if (state_q == IDLE || strided_d) begin
            eff_addr_d = addr;
        end else begin
            eff_addr_d = sum_d[AW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (we_d) begin
            mem[eff_addr_d] <= wrdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            base_q        <= '0;
            mode_q        <= '0;
            len_q         <= '0;
            beat_q        <= '0;
            rddata_q      <= '0;
            rddatavalid_q <= 1'b0;
            perr_q        <= 1'b0;
        end else begin
            perr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rd || wr) begin
                        base_q <= addr;
                        mode_q <= mode;
                        len_q  <= len_d;
                    end
                    if (rd) begin
                        beat_q  <= '0;
                        perr_q  <= bad_len_d || wr;
                        state_q <= READ_FETCH;
                    end else if (wr) begin
                        perr_q <= bad_len_d;
                        if (len_d == LW'(1)) begin
                            beat_q  <= '0;
                            state_q <= IDLE;
                        end else begin
                            beat_q  <= LW'(1);
                            state_q <= WRITE_BURST;
                        end
                    end
                end
                WRITE_BURST: begin
                    if (wr) begin
                        if (last_d) begin
                            state_q <= IDLE;
                        end else begin
                            beat_q <= beat_q + LW'(1);
                        end
                    end
                end
                READ_FETCH: begin
                    rddata_q      <= mem[eff_addr_d];
                    rddatavalid_q <= 1'b1;
                    state_q       <= READ_VALID;
                end
                READ_VALID: begin
                    if (rddataready) begin
                        rddatavalid_q <= 1'b0;
                        if (last_d) begin
                            state_q <= IDLE;
                        end else begin
                            beat_q  <= beat_q + LW'(1);
                            state_q <= READ_FETCH;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_completer.sv
// Directed self-checking bench for mem_completer with hand-computed expectations.
module tb_mem_completer;

    logic        clk;
    logic        rst;
    logic        rd;
    logic        wr;
    logic [14:0] addr;
    logic [5:0]  length;
    logic [1:0]  mode;
    logic [31:0] wrdata;
    logic        rddataready;
    logic        ready;
    logic [31:0] rddata;
    logic        rddatavalid;
    logic        busy;
    logic        protocol_err;

    int checks;
    int errors;

    logic [31:0] exp_data  [0:7];
    logic [14:0] beat_addr [0:7];

    mem_completer #(
        .ADDR_RANGE  (32768),
        .LENGTH_RANGE(32),
        .BUS_WIDTH   (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd          (rd),
        .wr          (wr),
        .addr        (addr),
        .length      (length),
        .mode        (mode),
        .wrdata      (wrdata),
        .rddataready (rddataready),
        .ready       (ready),
        .rddata      (rddata),
        .rddatavalid (rddatavalid),
        .busy        (busy),
        .protocol_err(protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Later unit-stride beats drive a junk address that must be ignored.
    task automatic do_write(input logic [14:0] base, input logic [1:0] md,
                            input logic [5:0] len, input int n);
        for (int k = 0; k < n; k++) begin
            wr     = 1'b1;
            rd     = (k > 0);
            mode   = md;
            length = (k == 0) ? len : 6'h3F;
            addr   = md[1] ? beat_addr[k] : ((k == 0) ? base : 15'h5555);
            wrdata = exp_data[k];
            checks++;
            if (ready !== 1'b1) begin
                errors++;
                $display("FAIL wr_ready beat %0d: got %b expected 1", k, ready);
            end
            tick();
            checks++;
            if (busy !== (k + 1 < int'(len))) begin
                errors++;
                $display("FAIL wr_busy beat %0d: got %b expected %b", k, busy, (k + 1 < int'(len)));
            end
            if (k == 0) begin
                checks++;
                if (protocol_err !== 1'b0) begin
                    errors++;
                    $display("FAIL wr_perr: got %b expected 0", protocol_err);
                end
            end
        end
        wr = 1'b0;
        rd = 1'b0;
    endtask

    // wr is held high during read states with junk data; it must be ignored.
    task automatic do_read(input logic [14:0] base, input logic [1:0] md,
                           input logic [5:0] len, input int bp_beat, input int bp_cycles);
        rd          = 1'b1;
        wr          = 1'b0;
        addr        = base;
        mode        = md;
        length      = len;
        rddataready = 1'b0;
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL rd_ready: got %b expected 1", ready);
        end
        tick();
        rd     = 1'b0;
        wr     = 1'b1;
        wrdata = 32'hBAD0BAD0;
        for (int j = 0; j < int'(len); j++) begin
            addr = md[1] ? beat_addr[j] : 15'h5555;
            checks++;
            if ({rddatavalid, ready, busy} !== 3'b001) begin
                errors++;
                $display("FAIL rd_fetch beat %0d: got valid/ready/busy %b expected 001", j, {rddatavalid, ready, busy});
            end
            tick();
            checks++;
            if (rddatavalid !== 1'b1 || rddata !== exp_data[j]) begin
                errors++;
                $display("FAIL rd_data beat %0d: got valid %b data %h expected 1 %h", j, rddatavalid, rddata, exp_data[j]);
            end
            if (j == bp_beat) begin
                for (int c = 0; c < bp_cycles; c++) begin
                    rddataready = 1'b0;
                    tick();
                    checks++;
                    if (rddatavalid !== 1'b1 || rddata !== exp_data[j]) begin
                        errors++;
                        $display("FAIL rd_hold beat %0d cyc %0d: got valid %b data %h expected 1 %h", j, c, rddatavalid, rddata, exp_data[j]);
                    end
                end
            end
            rddataready = 1'b1;
            tick();
            rddataready = 1'b0;
        end
        wr = 1'b0;
        checks++;
        if (busy !== 1'b0 || rddatavalid !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL rd_end: got busy %b valid %b ready %b expected 0 0 1", busy, rddatavalid, ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; length = '0;
        mode = '0; wrdata = '0; rddataready = 1'b0;
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({busy, ready, rddatavalid, protocol_err} !== 4'b0100 || rddata !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: got busy/ready/valid/perr %b data %h expected 0100 0", {busy, ready, rddatavalid, protocol_err}, rddata);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_unit_stride();
        for (int i = 0; i < 8; i++) exp_data[i] = 32'hA0 + i;
        do_write(15'h100, 2'b01, 6'd8, 8);
        do_read(15'h100, 2'b01, 6'd8, -1, 0);
        exp_data[0] = 32'hA0;
        do_read(15'h100, 2'b00, 6'd1, -1, 0);
    endtask

    task automatic test_strided_backpressure();
        for (int i = 0; i < 4; i++) begin
            beat_addr[i] = 15'h10 + 15'(4 * i);
            exp_data[i]  = 32'h5000_0010 + 32'(4 * i);
        end
        do_write(15'h10, 2'b10, 6'd4, 4);
        do_read(15'h10, 2'b10, 6'd4, 1, 3);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 4; i++) exp_data[i] = 32'h7777_0000 + i;
        do_write(15'd32766, 2'b01, 6'd4, 4);
        beat_addr[0] = 15'd32766;
        beat_addr[1] = 15'd32767;
        beat_addr[2] = 15'd0;
        beat_addr[3] = 15'd1;
        do_read(15'd32766, 2'b11, 6'd4, -1, 0);
    endtask

    task automatic test_malformed();
        exp_data[0] = 32'h1234_0200;
        exp_data[1] = 32'h1234_0201;
        do_write(15'h200, 2'b01, 6'd2, 2);
        wr = 1'b1; addr = 15'h200; length = 6'd0; mode = 2'b01; wrdata = 32'hDEAD_0000;
        tick();
        wr = 1'b0;
        checks++;
        if (protocol_err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL len0_perr: got perr %b busy %b expected 1 0", protocol_err, busy);
        end
        tick();
        checks++;
        if (protocol_err !== 1'b0) begin
            errors++;
            $display("FAIL len0_pulse: got %b expected 0", protocol_err);
        end
        wr = 1'b1; addr = 15'h202; length = 6'd33; wrdata = 32'h0000_0033;
        tick();
        wr = 1'b0;
        checks++;
        if (protocol_err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL len33_perr: got perr %b busy %b expected 1 0", protocol_err, busy);
        end
        beat_addr[0] = 15'h200; beat_addr[1] = 15'h201; beat_addr[2] = 15'h202;
        exp_data[0] = 32'hDEAD_0000; exp_data[1] = 32'h1234_0201; exp_data[2] = 32'h0000_0033;
        do_read(15'h200, 2'b10, 6'd3, -1, 0);

        exp_data[0] = 32'h1111_1111;
        do_write(15'h300, 2'b01, 6'd1, 1);
        rd = 1'b1; wr = 1'b1; addr = 15'h300; length = 6'd1; mode = 2'b01; wrdata = 32'h2222_2222;
        tick();
        rd = 1'b0; wr = 1'b0;
        checks++;
        if ({protocol_err, busy, ready} !== 3'b110) begin
            errors++;
            $display("FAIL rdwr_perr: got perr/busy/ready %b expected 110", {protocol_err, busy, ready});
        end
        tick();
        checks++;
        if (rddatavalid !== 1'b1 || rddata !== 32'h1111_1111 || protocol_err !== 1'b0) begin
            errors++;
            $display("FAIL rdwr_data: got valid %b data %h perr %b expected 1 11111111 0", rddatavalid, rddata, protocol_err);
        end
        rddataready = 1'b1;
        tick();
        rddataready = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rdwr_end: got busy %b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid_burst();
        for (int i = 0; i < 8; i++) exp_data[i] = 32'hC0 + i;
        do_write(15'h400, 2'b01, 6'd8, 3);
        wr  = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, ready, rddatavalid} !== 3'b010) begin
            errors++;
            $display("FAIL midrst_async: got busy/ready/valid %b expected 010", {busy, ready, rddatavalid});
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_idle: got busy %b ready %b expected 0 1", busy, ready);
        end
        exp_data[0] = 32'hC2;
        do_read(15'h402, 2'b01, 6'd1, -1, 0);
        exp_data[0] = 32'hC0;
        exp_data[1] = 32'hC1;
        exp_data[2] = 32'hC2;
        do_read(15'h400, 2'b01, 6'd3, -1, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_unit_stride();
        test_strided_backpressure();
        test_wrap();
        test_malformed();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
